// File: rtl/inv_sub_bytes_seq.sv
// inv_sub_bytes_seq: iterative AES InvSubBytes on a 128-bit state, BYTES_PER_CYCLE bytes per clock.
// Latency: out_valid rises NUM_STEPS cycles after the input handshake; one state per NUM_STEPS+2 cycles.
// Backpressure: in_ready low in BUSY/DONE; result held stable in DONE until out_ready.
// Optional macro INV_SBOX_SELFCHECK_EN: forward S-box cross-check with sticky selfcheck_err port.

// Inverse S-box lookup; entry 0 sits at the MSB end of the packed table.
module inv_s_box (
    input  logic [7:0] a,
    output logic [7:0] q
);
    localparam logic [2047:0] TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    // Plain table read: entry a occupies bits [2047-8a -: 8].
    always_comb begin
        q = TBL[2047 - 8 * int'(a) -: 8];
    end
endmodule

`ifdef INV_SBOX_SELFCHECK_EN
// Forward S-box lookup used only to cross-check the inverse table.
module s_box (
    input  logic [7:0] a,
    output logic [7:0] q
);
    localparam logic [2047:0] TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Plain table read, same layout as the inverse table.
    always_comb begin
        q = TBL[2047 - 8 * int'(a) -: 8];
    end
endmodule
`endif

module inv_sub_bytes_seq #(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
`ifdef INV_SBOX_SELFCHECK_EN
    ,
    output logic         selfcheck_err
`endif
);
    localparam int NUM_STEPS = 16 / BYTES_PER_CYCLE;
    localparam int STEP_W    = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam int SLICE_W   = 8 * BYTES_PER_CYCLE;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    generate
        if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
              BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bpc_check
            $error("inv_sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    logic [1:0]         state;
    logic [STEP_W-1:0]  step;
    logic [127:0]       work;
    logic [6:0]         slice_top;
    logic [SLICE_W-1:0] cur_slice;
    logic [SLICE_W-1:0] sub_slice;

    // Byte 0 is the MSB byte, so step s covers the slice whose top bit is 127 - SLICE_W*s.
    always_comb begin
        slice_top = 7'(127 - SLICE_W * int'(step));
        cur_slice = work[slice_top -: SLICE_W];
    end

    for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_sbox
        inv_s_box u_inv (
            .a (cur_slice[SLICE_W-1-8*g -: 8]),
            .q (sub_slice[SLICE_W-1-8*g -: 8])
        );
    end

    // Control FSM and working register; the step counter parks on its last value in BUSY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            step  <= '0;
            work  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        work  <= in_data;
                        step  <= '0;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    work[slice_top -: SLICE_W] <= sub_slice;
                    if (step == LAST_STEP) begin
                        state <= ST_DONE;
                    end else begin
                        step <= step + STEP_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);
    assign out_data  = work;

`ifdef INV_SBOX_SELFCHECK_EN
    logic [BYTES_PER_CYCLE-1:0] chk_bad;

    for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_fwd
        logic [7:0] fwd;
        s_box u_fwd (
            .a (sub_slice[SLICE_W-1-8*g -: 8]),
            .q (fwd)
        );
        assign chk_bad[g] = (fwd != cur_slice[SLICE_W-1-8*g -: 8]);
    end

    // Sticky error: any substituted byte that does not map back to its source.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            selfcheck_err <= 1'b0;
        end else if (state == ST_BUSY && |chk_bad) begin
            selfcheck_err <= 1'b1;
        end
    end
`endif
endmodule

// File: doc/inv_sub_bytes_seq.md
Name: inv_sub_bytes_seq

Overview:
- Iterative AES InvSubBytes engine for the decryption datapath: the inverse of the forward byte substitution.
- Accepts a 128-bit state over a valid/ready handshake and applies the inverse S-box to BYTES_PER_CYCLE bytes per clock.
- Returns the substituted state over a second valid/ready handshake.
- Sits between InvShiftRows and AddRoundKey in the decryption round; one instance per decrypt core.

Parameters:
- BYTES_PER_CYCLE, 4, bytes substituted per clock; legal values 1, 2, 4, 8, 16.
- NUM_STEPS, 16/BYTES_PER_CYCLE, derived localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data valid
- in_ready  output  1  block can accept a state
- in_data  input  128  ciphertext-side state; byte 0 = [127:120], byte 15 = [7:0]
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts out_data
- out_data  output  128  inverse-substituted state, same byte order
- busy  output  1  high in BUSY or DONE

Behaviour:
- Reset is asynchronous and active-low on rst_n; the block has one clock, clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, out_data=128'h0, step counter=0.
- Inverse S-box: 256-entry combinational table per FIPS-197 (inv(0x63)=0x00, inv(0x16)=0xFF, inv(0x52)... is the table value). BYTES_PER_CYCLE parallel instances.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, capture in_data into the working register, clear the step counter and go to BUSY.
  - in_data is ignored while in_valid is low.
- BUSY:
  - in_ready=0.
  - Each cycle, replace bytes [step*BPC .. step*BPC+BPC-1] of the working register with their inverse.
  - Increment step; after the step NUM_STEPS-1 update, go to DONE.
- DONE:
  - out_valid=1; out_data = working register, held stable until out_valid&out_ready.
  - On handshake, go to IDLE and drop out_valid next cycle.
  - out_ready held low = indefinite stall with no data change.
- Latency: input handshake at edge k -> out_valid high after edge k+NUM_STEPS (4 cycles at default; 1 cycle when BPC=16).
- Throughput: one state per NUM_STEPS+2 cycles minimum. in_ready is low in DONE, so there is no accept in the same cycle as the output handshake.
- out_ready asserted outside DONE has no effect.
- Step counter width is clog2(NUM_STEPS) with a minimum of 1 bit. It never wraps past NUM_STEPS-1.
- rst_n asserted mid-BUSY or mid-DONE: immediate return to reset values; the partial state is discarded and no out_valid is produced.
- Illegal BYTES_PER_CYCLE: elaboration-time error via a generate-time check.

Optional Feature:
- Macro: INV_SBOX_SELFCHECK_EN.
- Defined:
  - Each substituted byte is passed through the existing forward s_box module and compared with the original byte in the same cycle.
  - Any mismatch sets a sticky output port selfcheck_err (1 bit, reset 0, cleared only by rst_n).
- Undefined: port selfcheck_err and the forward s_box instances are absent; timing and behaviour are otherwise identical.

Test Plan:
- Default params; in_data=128'h637c777bf26b6fc53001672bfed7ab76 with out_ready=1 -> out_data=128'h000102030405060708090a0b0c0d0e0f, out_valid rising exactly 4 cycles after the input handshake.
- in_data all 0x16 -> out_data all 0xFF. in_data all 0x63 -> all 0x00. Sweep all 256 byte values (16 states) against the FIPS-197 inverse table -> zero mismatches.
- Hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, out_data constant, in_ready stays 0. Assert out_ready -> IDLE and in_ready=1 the next cycle.
- Pulse rst_n low at step 2 of BUSY -> out_valid=0, in_ready=1, out_data=0 asynchronously. A new state accepted afterwards produces the correct result.
- Repeat the first scenario with BYTES_PER_CYCLE=1 and 16 -> identical out_data, latency 16 and 1 cycles respectively.
- With INV_SBOX_SELFCHECK_EN defined, run the full sweep -> selfcheck_err remains 0. Force one table entry wrong -> selfcheck_err=1 and sticky until reset.
